// File: rtl/pong_match_ctrl_if.sv
// Match controller bus: game inputs from the ball mover/buttons,
// serve command, paddle gate and renderer outputs.
interface pong_match_ctrl_if #(
    parameter int SCORE_W = 4
);
    logic               start;
    logic               frame_tick;
    logic               miss_left;
    logic               miss_right;
    logic               ball_start;
    logic               serve_right;
    logic               paddles_en;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic [2:0]         state_o;
    logic [1:0]         winner;

    modport master (
        input  start, frame_tick, miss_left, miss_right,
        output ball_start, serve_right, paddles_en,
        output score1, score2, state_o, winner
    );

    modport slave (
        output start, frame_tick, miss_left, miss_right,
        input  ball_start, serve_right, paddles_en,
        input  score1, score2, state_o, winner
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve countdown, rally, point pause,
// scoring and game-over, with registered outputs.
module pong_match_ctrl #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 120,
    parameter int POINT_TICKS = 60,
    parameter int SCORE_W     = 4
) (
    input  logic clk,
    input  logic rst_n,
    pong_match_ctrl_if.master bus
);
    localparam int MAXT = (SERVE_TICKS > POINT_TICKS) ?
                          SERVE_TICKS : POINT_TICKS;
    localparam int TW = $clog2(MAXT + 1);
    localparam logic [TW-1:0] SERVE_LAST = TW'(SERVE_TICKS - 1);
    localparam logic [TW-1:0] POINT_LAST = TW'(POINT_TICKS - 1);
    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [TW-1:0]      tick_q, tick_d;
    logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [SCORE_W-1:0] s1_inc, s2_inc;
    logic [1:0]         win_q, win_d;
    logic               dir_q, dir_d;
    logic               bs_q, bs_d;
    logic               pad_q, pad_d;
    logic               start_q;
    logic               start_rise;
    logic               ml, mr;

    assign start_rise = bus.start & ~start_q;
    assign ml = bus.miss_left;
    assign mr = bus.miss_right;
    assign s1_inc = s1_q + SCORE_W'(1);
    assign s2_inc = s2_q + SCORE_W'(1);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        win_d   = win_q;
        dir_d   = dir_q;
        bs_d    = 1'b0;
        unique case (state_q)
            IDLE, OVER: begin
                if (start_rise) begin
                    s1_d    = '0;
                    s2_d    = '0;
                    win_d   = 2'd0;
                    dir_d   = 1'b1;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (bus.frame_tick) begin
                    if (tick_q == SERVE_LAST) begin
                        bs_d    = 1'b1;
                        state_d = PLAY;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            PLAY: begin
                unique case (1'b1)
                    (ml & mr): state_d = POINT;
                    (ml & ~mr): begin
                        s2_d  = s2_inc;
                        dir_d = 1'b0;
                        if (s2_inc == WIN) begin
                            win_d   = 2'd2;
                            state_d = OVER;
                        end else begin
                            state_d = POINT;
                        end
                    end
                    (mr & ~ml): begin
                        s1_d  = s1_inc;
                        dir_d = 1'b1;
                        if (s1_inc == WIN) begin
                            win_d   = 2'd1;
                            state_d = OVER;
                        end else begin
                            state_d = POINT;
                        end
                    end
                    default: ;
                endcase
            end
            POINT: begin
                if (bus.frame_tick) begin
                    if (tick_q == POINT_LAST) begin
                        state_d = SERVE;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // every state entry restarts the frame countdown
        if (state_d != state_q) begin
            tick_d = '0;
        end
        pad_d = (state_d == SERVE) || (state_d == PLAY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            win_q   <= 2'd0;
            dir_q   <= 1'b1;
            bs_q    <= 1'b0;
            pad_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            win_q   <= win_d;
            dir_q   <= dir_d;
            bs_q    <= bs_d;
            pad_q   <= pad_d;
            start_q <= bus.start;
        end
    end

    assign bus.ball_start  = bs_q;
    assign bus.serve_right = dir_q;
    assign bus.paddles_en  = pad_q;
    assign bus.score1      = s1_q;
    assign bus.score2      = s2_q;
    assign bus.state_o     = state_q;
    assign bus.winner      = win_q;
endmodule
